// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - shared command layout, state encoding and defaults for the SPI register bridge
package spi_bridge_pkg;

  localparam int          CMD_WR_BIT        = 7;
  localparam int          CMD_AI_BIT        = 6;
  localparam int          CMD_RSVD_MSB      = 5;
  localparam logic [7:0]  STATUS_ID_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_DISCARD = 2'd3
  } bridge_state_t;

  // True when any bit between the address field and the auto-increment bit
  // is set. With a 6-bit address field there are no reserved bits left.
  function automatic logic cmd_reserved_set(input logic [7:0] cmd, input int addr_w);
    logic r;
    r = 1'b0;
    for (int i = 0; i <= CMD_RSVD_MSB; i++) begin
      if (i >= addr_w && cmd[i]) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - 2**ADDR_W x 8 register bank with SPI and host write ports
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   spi_we/spi_addr/spi_wdata    SPI-side write port (loses to a host write to the same address)
//   host_we/host_addr/host_wdata host-side write port
//   host_rdata                   registered read of reg[host_addr], 1-cycle latency
//   rd_en/rd_clr/rd_addr/rd_data registered SPI read port; rd_clr loads STATUS_ID instead of a register
module spi_reg_bank
  import spi_bridge_pkg::*;
#(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] STATUS_ID = STATUS_ID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [7:0]        spi_wdata,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else begin
      if (spi_we && !(host_we && host_addr == spi_addr)) regs[spi_addr] <= spi_wdata;
      if (host_we) regs[host_addr] <= host_wdata;
    end
  end

  // Read ports sample the array before this cycle's writes land, so a
  // same-cycle write is seen one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata <= 8'h00;
      rd_data    <= STATUS_ID;
    end else begin
      host_rdata <= regs[host_addr];
      if (rd_clr)     rd_data <= STATUS_ID;
      else if (rd_en) rd_data <= regs[rd_addr];
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI command decoder sharing a register bank with the host bus
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   ssel_n                                 raw SPI chip select (async, active low)
//   byte_received, byte_data_received      received-byte strobe and data from the SPI slave
//   byte_send                              registered next byte for the slave to shift out
//   host_addr/host_we/host_wdata           host-side register write port
//   host_rdata                             registered host read data, 1-cycle latency
//   spi_wr, spi_wr_addr                    commit pulse and address of the last SPI write
//   collision                              sticky: SPI write lost to a same-address host write
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] STATUS_ID = STATUS_ID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ssel_n,
  input  logic              byte_received,
  input  logic [7:0]        byte_data_received,
  output logic [7:0]        byte_send,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              spi_wr,
  output logic [ADDR_W-1:0] spi_wr_addr,
  output logic              collision
);

  bridge_state_t     state;
  logic [ADDR_W-1:0] ptr;
  logic              autoinc;

  // Synchroniser is left unreset so it keeps tracking chip select through a
  // reset; that is what lets a reset released mid-frame be detected.
  logic [1:0] ssel_sync;
  logic       rst_q;

  always_ff @(posedge clk) begin
    ssel_sync <= {ssel_sync[0], ssel_n};
    rst_q     <= rst;
  end

  logic frame_active;
  logic strobe;
  logic cmd_rsvd;
  logic cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] ptr_next;

  assign frame_active = ~ssel_sync[1];
  // The cycle right after reset is spent entering DISCARD, so no byte counts.
  assign strobe       = byte_received & frame_active & ~rst_q;
  assign cmd_rsvd     = cmd_reserved_set(byte_data_received, ADDR_W);
  assign cmd_wr       = byte_data_received[CMD_WR_BIT];
  assign cmd_addr     = byte_data_received[ADDR_W-1:0];
  assign ptr_next     = ptr + ADDR_W'(autoinc);

  logic              spi_we;
  logic              spi_drop;
  logic              rd_en;
  logic              rd_clr;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    spi_we  = 1'b0;
    rd_en   = 1'b0;
    rd_clr  = 1'b0;
    rd_addr = ptr_next;
    if (!frame_active) begin
      rd_clr = 1'b1;
    end else if (strobe) begin
      case (state)
        ST_IDLE: begin
          if (cmd_rsvd || cmd_wr) begin
            rd_clr = 1'b1;
          end else begin
            rd_en   = 1'b1;
            rd_addr = cmd_addr;
          end
        end
        ST_WRITE: begin
          spi_we = 1'b1;
          rd_clr = 1'b1;
        end
        ST_READ: begin
          rd_en   = 1'b1;
          rd_addr = ptr_next;
        end
        default: rd_clr = 1'b1;
      endcase
    end
  end

  assign spi_drop = spi_we & host_we & (host_addr == ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      autoinc     <= 1'b0;
      spi_wr      <= 1'b0;
      spi_wr_addr <= '0;
      collision   <= 1'b0;
    end else begin
      spi_wr <= spi_we & ~spi_drop;
      if (spi_we && !spi_drop) spi_wr_addr <= ptr;

      // A new collision outranks a same-cycle clear from a host write to 0.
      if (spi_drop)                      collision <= 1'b1;
      else if (host_we && host_addr == '0) collision <= 1'b0;

      if (!frame_active) begin
        state <= ST_IDLE;
      end else if (rst_q) begin
        state <= ST_DISCARD;
      end else if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (cmd_rsvd) begin
              state <= ST_DISCARD;
            end else begin
              state   <= cmd_wr ? ST_WRITE : ST_READ;
              ptr     <= cmd_addr;
              autoinc <= byte_data_received[CMD_AI_BIT];
            end
          end
          ST_WRITE: ptr <= ptr_next;
          ST_READ:  ptr <= ptr_next;
          default:  state <= ST_DISCARD;
        endcase
      end
    end
  end

  spi_reg_bank #(
    .ADDR_W    (ADDR_W),
    .STATUS_ID (STATUS_ID)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .spi_we     (spi_we),
    .spi_addr   (ptr),
    .spi_wdata  (byte_data_received),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .rd_en      (rd_en),
    .rd_clr     (rd_clr),
    .rd_addr    (rd_addr),
    .rd_data    (byte_send)
  );

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - directed self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ssel_n = 1'b1;
  logic       byte_received = 1'b0;
  logic [7:0] byte_data_received = 8'h00;
  logic [7:0] byte_send;
  logic [3:0] host_addr = 4'h0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       spi_wr;
  logic [3:0] spi_wr_addr;
  logic       collision;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_reg_bridge #(.ADDR_W(4), .STATUS_ID(8'hA5)) dut (
    .clk                (clk),
    .rst                (rst),
    .ssel_n             (ssel_n),
    .byte_received      (byte_received),
    .byte_data_received (byte_data_received),
    .byte_send          (byte_send),
    .host_addr          (host_addr),
    .host_we            (host_we),
    .host_wdata         (host_wdata),
    .host_rdata         (host_rdata),
    .spi_wr             (spi_wr),
    .spi_wr_addr        (spi_wr_addr),
    .collision          (collision)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive/sample on the falling edge; outputs checked after a byte reflect
  // the rising edge that consumed the strobe.
  task automatic frame_start();
    @(negedge clk) ssel_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk) ssel_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(negedge clk);
    byte_received = 1'b1;
    byte_data_received = b;
    @(negedge clk);
    byte_received = 1'b0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk) host_addr = a;
    @(negedge clk);
    check(tag, {24'h0, host_rdata}, {24'h0, exp});
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst byte_send", {24'h0, byte_send}, 32'hA5);
    check("rst host_rdata", {24'h0, host_rdata}, 32'h00);
    check("rst spi_wr", {31'h0, spi_wr}, 32'h0);
    check("rst spi_wr_addr", {28'h0, spi_wr_addr}, 32'h0);
    check("rst collision", {31'h0, collision}, 32'h0);

    // Write burst with auto-increment from address 2
    frame_start();
    send_byte(8'hC2);
    check("wr cmd byte_send", {24'h0, byte_send}, 32'hA5);
    check("wr cmd spi_wr", {31'h0, spi_wr}, 32'h0);
    send_byte(8'h11);
    check("wr1 spi_wr", {31'h0, spi_wr}, 32'h1);
    check("wr1 addr", {28'h0, spi_wr_addr}, 32'h2);
    check("wr1 byte_send", {24'h0, byte_send}, 32'hA5);
    @(negedge clk);
    check("wr1 pulse width", {31'h0, spi_wr}, 32'h0);
    send_byte(8'h22);
    check("wr2 addr", {28'h0, spi_wr_addr}, 32'h3);
    send_byte(8'h33);
    check("wr3 spi_wr", {31'h0, spi_wr}, 32'h1);
    check("wr3 addr", {28'h0, spi_wr_addr}, 32'h4);
    check("wr3 byte_send", {24'h0, byte_send}, 32'hA5);
    frame_end();
    host_check("reg2", 4'd2, 8'h11);
    host_check("reg3", 4'd3, 8'h22);
    host_check("reg4", 4'd4, 8'h33);

    // Read burst wrapping from 15 to 0
    host_write(4'd15, 8'h5A);
    host_write(4'd0, 8'h3C);
    frame_start();
    send_byte(8'h4F);
    check("rd wrap cmd", {24'h0, byte_send}, 32'h5A);
    send_byte(8'h00);
    check("rd wrap reg0", {24'h0, byte_send}, 32'h3C);
    send_byte(8'h00);
    check("rd wrap reg1", {24'h0, byte_send}, 32'h00);
    frame_end();
    check("frame end byte_send", {24'h0, byte_send}, 32'hA5);

    // Read without auto-increment sees a host update between slots
    frame_start();
    send_byte(8'h07);
    check("noai cmd", {24'h0, byte_send}, 32'h00);
    send_byte(8'hEE);
    check("noai slot1", {24'h0, byte_send}, 32'h00);
    host_write(4'd7, 8'h81);
    send_byte(8'hEE);
    check("noai slot2", {24'h0, byte_send}, 32'h81);
    frame_end();
    host_check("noai reg7 kept", 4'd7, 8'h81);

    // Reserved bits set: whole frame discarded
    frame_start();
    send_byte(8'hB0);
    check("rsvd cmd byte_send", {24'h0, byte_send}, 32'hA5);
    send_byte(8'hFF);
    check("rsvd spi_wr", {31'h0, spi_wr}, 32'h0);
    check("rsvd byte_send", {24'h0, byte_send}, 32'hA5);
    frame_end();
    host_check("rsvd reg0 kept", 4'd0, 8'h3C);
    frame_start();
    send_byte(8'h89);
    send_byte(8'h77);
    check("post rsvd spi_wr", {31'h0, spi_wr}, 32'h1);
    check("post rsvd addr", {28'h0, spi_wr_addr}, 32'h9);
    frame_end();
    host_check("reg9", 4'd9, 8'h77);

    // Same-cycle host/SPI write to reg5, then a non-colliding write to reg6
    frame_start();
    send_byte(8'hC5);
    repeat (2) @(negedge clk);
    byte_received = 1'b1; byte_data_received = 8'h44;
    host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'h99;
    @(negedge clk);
    byte_received = 1'b0; host_we = 1'b0;
    check("coll spi_wr", {31'h0, spi_wr}, 32'h0);
    check("coll flag", {31'h0, collision}, 32'h1);
    check("coll addr held", {28'h0, spi_wr_addr}, 32'h9);
    send_byte(8'h66);
    check("coll next spi_wr", {31'h0, spi_wr}, 32'h1);
    check("coll next addr", {28'h0, spi_wr_addr}, 32'h6);
    frame_end();
    host_check("reg5 host wins", 4'd5, 8'h99);
    host_check("reg6", 4'd6, 8'h66);
    check("coll sticky", {31'h0, collision}, 32'h1);
    host_write(4'd0, 8'h01);
    check("coll cleared", {31'h0, collision}, 32'h0);

    // Abort after the command byte: next frame starts with a command
    frame_start();
    send_byte(8'h83);
    frame_end();
    frame_start();
    send_byte(8'h03);
    check("abort new cmd", {24'h0, byte_send}, 32'h22);
    frame_end();
    host_check("abort reg3 kept", 4'd3, 8'h22);

    // Bytes outside a frame are ignored
    send_byte(8'hC1);
    send_byte(8'h55);
    check("idle spi_wr", {31'h0, spi_wr}, 32'h0);
    check("idle byte_send", {24'h0, byte_send}, 32'hA5);
    host_check("idle reg1", 4'd1, 8'h00);

    // Reset released mid-frame: rest of the frame is discarded
    frame_start();
    send_byte(8'hC2);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst byte_send", {24'h0, byte_send}, 32'hA5);
    send_byte(8'hC8);
    send_byte(8'h12);
    check("midrst spi_wr", {31'h0, spi_wr}, 32'h0);
    check("midrst byte_send2", {24'h0, byte_send}, 32'hA5);
    frame_end();
    host_check("midrst reg8", 4'd8, 8'h00);
    frame_start();
    send_byte(8'hC8);
    send_byte(8'h12);
    check("after midrst spi_wr", {31'h0, spi_wr}, 32'h1);
    check("after midrst addr", {28'h0, spi_wr_addr}, 32'h8);
    frame_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
